mcu_scheduler: RTL and testbench

Sequences the coefficient streams of one frame through the shared run encoder. Holds three component sources (Y, Cb, Cr), each presenting 64-coefficient zigzag-ordered blocks. Each block is granted in MCU order (grayscale, 4:4:4 or 4:2:0). The DC coefficient is replaced by its difference from the same component's previous DC. The block drives the Huffman table select, inserts restart-interval boundaries and flags frame completion.

---
 rtl/mcu_scheduler_if.sv | 49 ++++
 rtl/mcu_scheduler.sv | 221 ++++++++++++++++++++++
 tb/tb_mcu_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcu_scheduler_if.sv
// Frame-scheduler bus: frame configuration, the three component sources,
// the run-encoder link and the frame/restart status lines.
interface mcu_scheduler_if;
  logic               start;
  logic [1:0]         mode;
  logic [15:0]        num_mcus;
  logic [15:0]        restart_interval;

  logic signed [10:0] y_coef;
  logic signed [10:0] cb_coef;
  logic signed [10:0] cr_coef;
  logic               y_ena;
  logic               cb_ena;
  logic               cr_ena;
  logic               y_rdy;
  logic               cb_rdy;
  logic               cr_rdy;

  logic signed [10:0] enc_coef;
  logic               enc_ena;
  logic               enc_rdy;
  logic               enc_done;

  logic               chroma;
  logic               restart;
  logic               restart_ack;
  logic               busy;
  logic               frame_done;

  modport slave (
    input  start, mode, num_mcus, restart_interval,
    input  y_coef, cb_coef, cr_coef, y_ena, cb_ena, cr_ena,
    output y_rdy, cb_rdy, cr_rdy,
    output enc_coef, enc_ena,
    input  enc_rdy, enc_done,
    output chroma, restart, busy, frame_done,
    input  restart_ack
  );

  modport master (
    output start, mode, num_mcus, restart_interval,
    output y_coef, cb_coef, cr_coef, y_ena, cb_ena, cr_ena,
    input  y_rdy, cb_rdy, cr_rdy,
    input  enc_coef, enc_ena,
    output enc_rdy, enc_done,
    input  chroma, restart, busy, frame_done,
    output restart_ack
  );
endinterface

// File: rtl/mcu_scheduler.sv
// Frame scheduler: grants Y/Cb/Cr coefficient blocks to the shared run
// encoder in MCU order, DPCM-codes the DC term, requests restart markers
// and flags frame completion.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | waiting for start; all outputs quiet
//   S_STREAM  | selected source wired straight through to the encoder
//   S_DRAIN   | 64 coefficients sent, waiting for encoder enc_done
//   S_RESTART | restart marker requested, predictors held at zero
//   S_DONE    | one-cycle frame_done pulse
module mcu_scheduler (
  input  logic           clk,
  input  logic           rst,
  mcu_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_STREAM, S_DRAIN, S_RESTART, S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [1:0]         r_mode;      // 0 gray, 1 4:4:4, 2 4:2:0
  logic [15:0]        r_num_mcus;
  logic [15:0]        r_rst_int;
  logic [15:0]        r_mcu_cnt;
  logic [15:0]        r_rst_cnt;
  logic [2:0]         r_blk_idx;
  logic [5:0]         r_coef_idx;
  logic signed [10:0] r_pred_y;
  logic signed [10:0] r_pred_cb;
  logic signed [10:0] r_pred_cr;

  logic [1:0]         w_comp;      // 0 Y, 1 Cb, 2 Cr
  logic [2:0]         w_last_idx;
  logic               w_sel_ena;
  logic signed [10:0] w_sel_coef;
  logic signed [10:0] w_sel_pred;
  logic signed [11:0] w_diff;
  logic signed [10:0] w_dc;
  logic               w_xfer;
  logic               w_blk_last;
  logic [15:0]        w_mcu_cnt_inc;
  logic [15:0]        w_rst_cnt_inc;
  logic               w_frame_end;
  logic               w_rst_hit;

  // Map block index within the MCU to its component for the latched mode.
  always_comb begin
    w_comp     = 2'd0;
    w_last_idx = 3'd0;
    case (r_mode)
      2'd1: begin
        w_last_idx = 3'd2;
        w_comp     = r_blk_idx[1:0];
      end
      2'd2: begin
        w_last_idx = 3'd5;
        if (r_blk_idx == 3'd4)      w_comp = 2'd1;
        else if (r_blk_idx == 3'd5) w_comp = 2'd2;
      end
      default: ;
    endcase
  end

  // Source mux plus the predictor belonging to the selected component.
  always_comb begin
    w_sel_ena  = bus.y_ena;
    w_sel_coef = bus.y_coef;
    w_sel_pred = r_pred_y;
    case (w_comp)
      2'd1: begin
        w_sel_ena  = bus.cb_ena;
        w_sel_coef = bus.cb_coef;
        w_sel_pred = r_pred_cb;
      end
      2'd2: begin
        w_sel_ena  = bus.cr_ena;
        w_sel_coef = bus.cr_coef;
        w_sel_pred = r_pred_cr;
      end
      default: ;
    endcase
  end

  // DC difference at 12 bits, clamped back into the symmetric 11-bit range.
  always_comb begin
    w_diff = {w_sel_coef[10], w_sel_coef} - {w_sel_pred[10], w_sel_pred};
    if (w_diff > 12'sd1023)       w_dc = 11'sd1023;
    else if (w_diff < -12'sd1023) w_dc = -11'sd1023;
    else                          w_dc = w_diff[10:0];
  end

  assign w_xfer        = (r_state == S_STREAM) && w_sel_ena && bus.enc_rdy;
  assign w_blk_last    = (r_blk_idx == w_last_idx);
  assign w_mcu_cnt_inc = r_mcu_cnt + 16'd1;
  assign w_rst_cnt_inc = r_rst_cnt + 16'd1;
  // Frame end outranks a coinciding restart.
  assign w_frame_end   = w_blk_last && (w_mcu_cnt_inc == r_num_mcus);
  assign w_rst_hit     = w_blk_last && !w_frame_end && (r_rst_int != 16'd0) &&
                         (w_rst_cnt_inc == r_rst_int);
  assign bus.chroma    = (r_state != S_IDLE) && (w_comp != 2'd0);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state decode and the handshake/status outputs.
  always_comb begin
    w_state_nxt    = r_state;
    bus.y_rdy      = 1'b0;
    bus.cb_rdy     = 1'b0;
    bus.cr_rdy     = 1'b0;
    bus.enc_ena    = 1'b0;
    bus.enc_coef   = '0;
    bus.restart    = 1'b0;
    bus.busy       = 1'b1;
    bus.frame_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) w_state_nxt = (bus.num_mcus == 16'd0) ? S_DONE : S_STREAM;
      end
      S_STREAM: begin
        bus.enc_ena  = w_sel_ena;
        bus.enc_coef = (r_coef_idx == 6'd0) ? w_dc : w_sel_coef;
        case (w_comp)
          2'd1:    bus.cb_rdy = bus.enc_rdy;
          2'd2:    bus.cr_rdy = bus.enc_rdy;
          default: bus.y_rdy  = bus.enc_rdy;
        endcase
        if (w_xfer && (r_coef_idx == 6'd63)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (bus.enc_done) begin
          if (w_frame_end)    w_state_nxt = S_DONE;
          else if (w_rst_hit) w_state_nxt = S_RESTART;
          else                w_state_nxt = S_STREAM;
        end
      end
      S_RESTART: begin
        bus.restart = 1'b1;
        if (bus.restart_ack) w_state_nxt = S_STREAM;
      end
      S_DONE: begin
        bus.frame_done = 1'b1;
        w_state_nxt    = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Config latch, block/coef indices, MCU/restart counters and DC predictors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode     <= 2'd0;
      r_num_mcus <= '0;
      r_rst_int  <= '0;
      r_mcu_cnt  <= '0;
      r_rst_cnt  <= '0;
      r_blk_idx  <= '0;
      r_coef_idx <= '0;
      r_pred_y   <= '0;
      r_pred_cb  <= '0;
      r_pred_cr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mode     <= (bus.mode == 2'd3) ? 2'd2 : bus.mode;
            r_num_mcus <= bus.num_mcus;
            r_rst_int  <= bus.restart_interval;
            r_mcu_cnt  <= '0;
            r_rst_cnt  <= '0;
            r_blk_idx  <= '0;
            r_coef_idx <= '0;
            r_pred_y   <= '0;
            r_pred_cb  <= '0;
            r_pred_cr  <= '0;
          end
        end
        S_STREAM: begin
          if (w_xfer) begin
            r_coef_idx <= r_coef_idx + 6'd1;
            if (r_coef_idx == 6'd0) begin
              case (w_comp)
                2'd1:    r_pred_cb <= w_sel_coef;
                2'd2:    r_pred_cr <= w_sel_coef;
                default: r_pred_y  <= w_sel_coef;
              endcase
            end
          end
        end
        S_DRAIN: begin
          if (bus.enc_done) begin
            r_blk_idx <= w_blk_last ? 3'd0 : r_blk_idx + 3'd1;
            if (w_blk_last) begin
              r_mcu_cnt <= w_mcu_cnt_inc;
              r_rst_cnt <= w_rst_hit ? 16'd0 : w_rst_cnt_inc;
            end
          end
        end
        S_RESTART: begin
          r_pred_y  <= '0;
          r_pred_cb <= '0;
          r_pred_cr <= '0;
          if (bus.restart_ack) begin
            r_blk_idx  <= '0;
            r_coef_idx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_scheduler.sv
// Bench for mcu_scheduler: random/directed frames, expected encoder stream
// built from the MCU ordering and DPCM rules, checked by a negedge monitor.
`timescale 1ns/1ps
module tb_mcu_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mcu_scheduler_if bus();

  mcu_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int                 comp;
    logic signed [10:0] coef;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  int   dc_list[$];

  logic signed [10:0] src_mem [3][4096];
  int   src_wr [3];
  int   src_rd [3];
  logic signed [10:0] src_coef [3];
  logic src_ena [3];
  logic acc [3];

  bit   abort   = 1'b0;
  bit   gaps    = 1'b0;
  bit   bp      = 1'b0;
  int   ack_dly = 4;
  int   cyc     = 0;
  int   done_due = -1;
  int   n_fd    = 0;
  int   n_restart = 0;

  assign bus.y_coef  = src_coef[0];
  assign bus.cb_coef = src_coef[1];
  assign bus.cr_coef = src_coef[2];
  assign bus.y_ena   = src_ena[0];
  assign bus.cb_ena  = src_ena[1];
  assign bus.cr_ena  = src_ena[2];

  wire logic [2:0] w_rdy = {bus.cr_rdy, bus.cb_rdy, bus.y_rdy};

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Component sources: present queued coefficients, optionally with idle gaps.
  initial begin
    for (int c = 0; c < 3; c++) begin
      src_ena[c]  = 1'b0;
      src_coef[c] = '0;
    end
    forever begin
      @(posedge clk); #1;
      for (int c = 0; c < 3; c++) begin
        if (abort) src_ena[c] = 1'b0;
        else begin
          if (src_ena[c] && acc[c]) begin
            src_rd[c]  = src_rd[c] + 1;
            src_ena[c] = 1'b0;
          end
          if (!src_ena[c] && (src_rd[c] < src_wr[c]) && (!gaps || $urandom_range(3) != 0)) begin
            src_ena[c]  = 1'b1;
            src_coef[c] = src_mem[c][src_rd[c] % 4096];
          end
        end
      end
    end
  end

  // Encoder ready, optionally random backpressure.
  initial begin
    bus.enc_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.enc_rdy = bp ? 1'($urandom_range(1)) : 1'b1;
    end
  end

  // Encoder block-complete pulse, scheduled by the monitor.
  initial begin
    bus.enc_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.enc_done = (done_due == cyc);
    end
  end

  // Marker writer: acknowledges restart ack_dly cycles after it rises.
  initial begin
    int rcnt;
    rcnt = 0;
    bus.restart_ack = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (bus.restart) begin
        bus.restart_ack = (rcnt >= ack_dly);
        rcnt++;
      end else begin
        rcnt = 0;
        bus.restart_ack = 1'b0;
      end
    end
  end

  // Monitor: scoreboard pop on every encoder transfer, event counters.
  initial begin
    exp_t       e;
    int         blk_xfer;
    logic       prev_rs;
    logic [2:0] oh;
    blk_xfer = 0;
    prev_rs  = 1'b0;
    forever begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) acc[c] = src_ena[c] && w_rdy[c];
      if (abort) begin
        blk_xfer = 0;
        done_due = -1;
      end
      if (bus.restart) chk("no_xfer_in_restart", {63'd0, bus.enc_ena}, 64'd0);
      if (bus.restart && !prev_rs) n_restart++;
      prev_rs = bus.restart;
      if (bus.frame_done) n_fd++;
      if (bus.enc_ena && bus.enc_rdy) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_xfer: got coef %0d with nothing expected (t=%0t)", bus.enc_coef, $time);
        end else begin
          e  = exp_q.pop_front();
          oh = 3'b001 << e.comp;
          chk("xfer", {49'd0, bus.chroma, w_rdy, bus.enc_coef},
                      {49'd0, (e.comp != 0), oh, e.coef});
        end
        blk_xfer++;
        if (blk_xfer == 64) begin
          blk_xfer = 0;
          done_due = cyc + 3;
        end
      end
    end
  end

  // Build source data and the expected encoder stream for one frame.
  task automatic prep_frame(input int md, input int n, input int ri, input bit ac_zero, output int exp_rst);
    int comps[$];
    int pred[3];
    int v, d, c;
    exp_t e;
    comps.push_back(0);
    if (md == 1) begin
      comps.push_back(1); comps.push_back(2);
    end else if (md >= 2) begin
      comps.push_back(0); comps.push_back(0); comps.push_back(0);
      comps.push_back(1); comps.push_back(2);
    end
    for (int i = 0; i < 3; i++) pred[i] = 0;
    exp_rst = 0;
    for (int m = 0; m < n; m++) begin
      if (ri != 0 && m != 0 && (m % ri) == 0) begin
        exp_rst++;
        for (int i = 0; i < 3; i++) pred[i] = 0;
      end
      foreach (comps[b]) begin
        c = comps[b];
        for (int k = 0; k < 64; k++) begin
          if (k == 0) v = (dc_list.size() > 0) ? dc_list.pop_front() : int'($urandom_range(2047)) - 1024;
          else        v = ac_zero ? 0 : int'($urandom_range(2047)) - 1024;
          src_mem[c][src_wr[c] % 4096] = 11'(v);
          src_wr[c] = src_wr[c] + 1;
          if (k == 0) begin
            d = v - pred[c];
            if (d > 1023)  d = 1023;
            if (d < -1023) d = -1023;
            pred[c] = v;
          end else d = v;
          e.comp = c;
          e.coef = 11'(d);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic start_frame(input string nm, input int md, input int n, input int ri);
    @(posedge clk); #1;
    bus.start            = 1'b1;
    bus.mode             = 2'(md);
    bus.num_mcus         = 16'(n);
    bus.restart_interval = 16'(ri);
    @(posedge clk); #1;
    bus.start            = 1'b0;
    bus.mode             = 2'($urandom_range(3));
    bus.num_mcus         = 16'($urandom_range(65535));
    bus.restart_interval = 16'($urandom_range(65535));
    chk({nm, "_busy"}, {63'd0, bus.busy}, 64'd1);
  endtask

  task automatic run_frame(input string nm, input int md, input int n, input int ri,
                           input bit bp_i, input bit gap_i, input bit ac_zero, input bit poke);
    int exp_rst, fd0, rs0, wc;
    bp   = bp_i;
    gaps = gap_i;
    prep_frame(md, n, ri, ac_zero, exp_rst);
    fd0 = n_fd;
    rs0 = n_restart;
    start_frame(nm, md, n, ri);
    wc = 0;
    while (n_fd == fd0 && wc < 30000) begin
      @(posedge clk); #1;
      wc++;
      if (poke && wc == 100) begin
        bus.start = 1'b1; bus.mode = 2'd0; bus.num_mcus = 16'd1; bus.restart_interval = 16'd0;
      end
      if (poke && wc == 101) bus.start = 1'b0;
    end
    if (n_fd == fd0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: frame_done not seen within %0d cycles", nm, wc);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
    repeat (4) @(posedge clk);
    #1;
    chk({nm, "_idle"}, {63'd0, bus.busy}, 64'd0);
    chk({nm, "_frame_done_cnt"}, 64'(n_fd - fd0), 64'd1);
    chk({nm, "_restarts"}, 64'(n_restart - rs0), 64'(exp_rst));
    chk({nm, "_left"}, 64'(exp_q.size()), 64'd0);
    bp   = 1'b0;
    gaps = 1'b0;
  endtask

  initial begin
    int er, fd0, wc;
    bus.start = 1'b0;
    bus.mode = 2'd0;
    bus.num_mcus = '0;
    bus.restart_interval = '0;

    #2;
    chk("reset_outputs",
        {49'd0, bus.y_rdy, bus.cb_rdy, bus.cr_rdy, bus.enc_ena, bus.enc_coef},
        64'd0);
    chk("reset_status", {60'd0, bus.chroma, bus.restart, bus.busy, bus.frame_done}, 64'd0);
    #20;
    @(posedge clk); #3;
    rst = 1'b1;

    dc_list.push_back(100); dc_list.push_back(40);
    run_frame("gray2", 0, 2, 0, 1'b0, 1'b0, 1'b1, 1'b0);

    dc_list.push_back(10); dc_list.push_back(20); dc_list.push_back(30);
    dc_list.push_back(40); dc_list.push_back(5);  dc_list.push_back(-7);
    run_frame("yuv420", 2, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0);

    dc_list.push_back(1023); dc_list.push_back(-1024); dc_list.push_back(1023);
    run_frame("clamp", 0, 3, 0, 1'b0, 1'b0, 1'b1, 1'b0);

    ack_dly = 4;
    run_frame("rst444", 1, 3, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    run_frame("backpressure", 2, 2, 0, 1'b1, 1'b1, 1'b0, 1'b1);

    ack_dly = 0;
    run_frame("mode3", 3, 3, 2, 1'b1, 1'b0, 1'b0, 1'b0);

    run_frame("empty", 1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a streaming block.
    prep_frame(0, 4, 0, 1'b0, er);
    start_frame("abandon", 0, 4, 0);
    wc = 0;
    while (!(bus.enc_ena && bus.enc_rdy) && wc < 1000) begin
      @(posedge clk); #1;
      wc++;
    end
    chk("abandon_streaming", {63'd0, bus.enc_ena}, 64'd1);
    repeat (20) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("midreset_outputs",
        {49'd0, bus.y_rdy, bus.cb_rdy, bus.cr_rdy, bus.enc_ena, bus.enc_coef},
        64'd0);
    chk("midreset_status", {60'd0, bus.chroma, bus.restart, bus.busy, bus.frame_done}, 64'd0);
    fd0 = n_fd;
    abort = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    for (int c = 0; c < 3; c++) src_wr[c] = src_rd[c];
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midreset_no_frame_done", 64'(n_fd - fd0), 64'd0);

    dc_list.push_back(55);
    run_frame("fresh", 0, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 4; i++) begin
      ack_dly = $urandom_range(3);
      run_frame($sformatf("rand%0d", i), $urandom_range(3), $urandom_range(1, 3),
                $urandom_range(2), 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
